// File: rtl/seq_compare_unit.sv
// Multi-cycle magnitude/equality comparator: scans two WIDTH-bit operands CHUNK bits
// per cycle, MSB chunk first. Define SEQ_COMPARE_EARLY_EXIT_EN to stop at the first difference.
module seq_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_neq,
  output logic             out_lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_neq;
  logic             r_lt;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_accept;
  logic             w_record;
  logic             w_last;

  // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
  always_comb begin
    w_ca = r_a[int'(r_idx)*CHUNK +: CHUNK];
    w_cb = r_b[int'(r_idx)*CHUNK +: CHUNK];
    if (r_signed && (r_idx == TOP_IDX)) begin
      w_ca[CHUNK-1] = ~w_ca[CHUNK-1];
      w_cb[CHUNK-1] = ~w_cb[CHUNK-1];
    end
  end

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_record = (r_state == SCAN) && !r_neq && (w_ca != w_cb);
  assign w_last   = (r_idx == '0);

  // NOTE: async reset in the sensitivity list; all state updates use non-blocking (<=).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block is given a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next_state = SCAN;
      end
      SCAN: begin
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
        if (w_last || w_record) w_next_state = DONE;
`else
        if (w_last) w_next_state = DONE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_neq    <= 1'b0;
      r_lt     <= 1'b0;
    end else if (w_accept) begin
      r_a      <= in_a;
      r_b      <= in_b;
      r_signed <= in_signed;
      r_idx    <= TOP_IDX;
      r_neq    <= 1'b0;
      r_lt     <= 1'b0;
    end else if (r_state == SCAN) begin
      // The first differing chunk (from the top) decides; later chunks never override it.
      if (w_record) begin
        r_neq <= 1'b1;
        r_lt  <= (w_ca < w_cb);
      end
      if (!w_last) r_idx <= r_idx - 1'b1;
    end
  end

  assign out_neq = r_neq;
  assign out_lt  = r_lt;

endmodule

// File: tb/tb_seq_compare_unit.sv
// Bench for seq_compare_unit (WIDTH=32, CHUNK=8): vector table plus scoreboard queue,
// with hand-written stall and reset-abort sequences.
module tb_seq_compare_unit;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        neq;
    logic        lt;
    int          lat_early;
  } vec_t;

  typedef struct {
    logic neq;
    logic lt;
    int   lat;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_neq;
  logic             out_lt;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  vec_t vecs[10];

  seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_neq  (out_neq),
    .out_lt   (out_lt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input vec_t v);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    return v.lat_early;
`else
    return NCHUNK;
`endif
  endfunction

  // Called at posedge+1; waits for in_ready, then presents one operation for one edge.
  task automatic drive(input vec_t v);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a      = v.a;
    in_b      = v.b;
    in_signed = v.sgn;
    in_valid  = 1'b1;
    @(posedge clock);
    e.neq = v.neq;
    e.lt  = v.lt;
    e.lat = exp_latency(v);
    sb.push_back(e);
    #1;
    in_valid  = 1'b0;
    in_a      = $urandom;
    in_b      = $urandom;
    in_signed = ~v.sgn;
  endtask

  // Counts edges after the accept edge until out_valid, then compares against the scoreboard.
  task automatic collect(input string name, output exp_t e);
    int cyc;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
      if (out_valid === 1'b1) break;
    end
    e = sb.pop_front();
    check({name, "_valid"},   32'(out_valid), 32'd1);
    check({name, "_latency"}, 32'(cyc),       32'(e.lat));
    check({name, "_neq"},     32'(out_neq),   32'(e.neq));
    check({name, "_lt"},      32'(out_lt),    32'(e.lt));
    check({name, "_busy"},    32'(in_ready),  32'd0);
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    drive(v);
    collect(v.name, e);
    @(posedge clock); #1;
    check({v.name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({v.name, "_idle"},       32'(in_ready),  32'd1);
  endtask

  initial begin
    exp_t e;
    int   pulses;

    vecs[0] = '{"equal",       32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 4};
    vecs[1] = '{"u_1_lt_2",    32'h00000001, 32'h00000002, 1'b0, 1'b1, 1'b1, 4};
    vecs[2] = '{"s_min_lt_1",  32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 1};
    vecs[3] = '{"u_min_gt_1",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{"s_m1_gt_m2",  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 4};
    vecs[5] = '{"s_max_gt_min",32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[6] = '{"u_max_lt_min",32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, 1};
    vecs[7] = '{"u_chunk2",    32'h12340000, 32'h12350000, 1'b0, 1'b1, 1'b1, 2};
    vecs[8] = '{"s_m3_lt_2",   32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b1, 1'b1, 1};
    vecs[9] = '{"s_equal_neg", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 4};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_neq",       32'(out_neq),   32'd0);
    check("reset_lt",        32'(out_lt),    32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Result held with out_ready low while a new request is offered.
    out_ready = 1'b0;
    drive(vecs[2]);
    collect("stall", e);
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_a      = 32'h00000001;
      in_b      = 32'h80000000;
      in_signed = 1'b0;
      @(posedge clock); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_neq",   32'(out_neq),   32'(e.neq));
      check("stall_lt",    32'(out_lt),    32'(e.lt));
      check("stall_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready),  32'd1);
    run_op(vecs[4]);

    // Reset two cycles into SCAN aborts the operation with no result pulse.
    drive(vecs[1]);
    sb.delete();
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_neq",       32'(out_neq),   32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    run_op('{"after_abort_5_gt_3", 32'd5, 32'd3, 1'b0, 1'b1, 1'b0, 4});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_compare_unit.md
Name: seq_compare_unit

Overview:
- Parametrised, multi-cycle successor to the combinational 32-bit equality reduction in the ALU.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Reports not-equal and less-than, in signed or unsigned mode.
- Valid/ready handshakes on both sides, so it can sit between the ALU operand latch and the branch/flag logic.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK; 1 <= CHUNK <= WIDTH.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode valid.
in_ready  output  1  unit can accept; equals (state==IDLE).
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_signed  input  1  1 = two's-complement compare, 0 = unsigned.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
out_neq  output  1  1 when A != B.
out_lt  output  1  1 when A < B under the captured mode.

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, out_neq=0, out_lt=0, operand regs=0, idx=0. in_ready=1 while in IDLE, including during reset.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On in_valid & in_ready at a rising edge, capture in_a, in_b, in_signed.
  - Clear neq/lt; set idx=NCHUNK-1; go to SCAN.
- SCAN:
  - Each cycle evaluates chunk idx: ca = a[idx*CHUNK +: CHUNK], cb likewise.
  - In signed mode, the top chunk (idx=NCHUNK-1) has its MSB inverted in both ca and cb before an unsigned compare. This yields a correct signed result.
  - If no difference is recorded yet and ca != cb: set neq=1 and lt=(ca<cb). Later chunks never overwrite a recorded difference.
  - idx decrements. After evaluating idx=0, go to DONE.
- DONE:
  - out_valid=1; out_neq/out_lt hold the final flags and stay stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready, go to IDLE at that edge; out_valid drops the next cycle.
- Latency: out_valid rises NCHUNK cycles after the accept edge (fixed, without the optional feature).
- Throughput: one operation per NCHUNK+2 cycles with out_ready held high. No overlap between operations.
- Equal operands: out_neq=0, out_lt=0.
- NCHUNK=1: single SCAN cycle.
- Reset mid-SCAN or mid-DONE: operation aborted, no out_valid pulse, result discarded.
- Input changes after the accept edge have no effect.
- out_ready while not in DONE: ignored.

Optional Feature:
- Macro: SEQ_COMPARE_EARLY_EXIT_EN.
- Defined:
  - SCAN goes to DONE in the same cycle that it records the first differing chunk.
  - Latency = number of chunks evaluated: 1 if the top chunks differ, NCHUNK if the operands are equal or differ only in chunk 0.
  - Results are identical to the undefined build.
- Undefined: fixed NCHUNK-cycle latency, as above.

Test Plan:
1. WIDTH=32, CHUNK=8, unsigned, A=B=0x12345678 -> out_neq=0, out_lt=0; out_valid rises 4 cycles after accept in both builds.
2. Unsigned, A=0x00000001, B=0x00000002 -> neq=1, lt=1; latency 4 in both builds (difference is in chunk 0).
3. A=0x80000000, B=0x00000001 -> signed: neq=1, lt=1; unsigned: neq=1, lt=0; latency 1 with SEQ_COMPARE_EARLY_EXIT_EN, 4 without.
4. Signed, A=0xFFFFFFFF, B=0xFFFFFFFE -> neq=1, lt=0 (-1 > -2).
5. Result reached with out_ready=0 held for 5 cycles, in_valid=1 with new operands -> out_valid, neq and lt stable; in_ready=0; new operands not captured. Raise out_ready -> IDLE, next operation accepted and correct.
6. Assert reset 2 cycles into SCAN -> out_valid=0 and in_ready=1 immediately, with no result pulse; next operation A=5, B=3 unsigned -> neq=1, lt=0.
